// File: rtl/kuz_rkey_store_pkg.sv
// Shared definitions for the Kuznyechik round-key store: geometry and capture FSM encoding.
package kuz_rkey_store_pkg;

    localparam int NPAIRS = 5;
    localparam int NKEYS  = 10;
    localparam int KEY_W  = 128;
    localparam int IDX_W  = 4;
    localparam int PAIR_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2
    } rk_state_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(NKEYS);
    endfunction

endpackage

// File: rtl/kuz_rkey_ram.sv
// 10x128 round-key register file: pair-wide write port, bulk clear, registered read port.
module kuz_rkey_ram
    import kuz_rkey_store_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [PAIR_W-1:0] wr_pair,
    input  logic [KEY_W-1:0]  wr_key1,
    input  logic [KEY_W-1:0]  wr_key2,
    input  logic              rd_req,
    input  logic              rd_ok,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [KEY_W-1:0]  rd_data,
    output logic              rd_valid
);

    logic [KEY_W-1:0] mem_reg [NKEYS];

    // Each slot owns its register so the whole array can be cleared in one edge.
    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_slot
            localparam logic [PAIR_W-1:0] PAIR = PAIR_W'(gi / 2);
            localparam bit                ODD  = (gi % 2) == 1;
            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && wr_pair == PAIR) begin
                    mem_reg[gi] <= ODD ? wr_key2 : wr_key1;
                end
            end
        end
    endgenerate

    // Reads sample the array before any same-edge clear or write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_req) begin
            if (rd_ok) begin
                rd_data  <= mem_reg[rd_idx];
                rd_valid <= 1'b1;
            end else begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/kuz_rkey_store.sv
// Captures a 10-key Kuznyechik schedule delivered as five key pairs and serves indexed reads.
module kuz_rkey_store
    import kuz_rkey_store_pkg::*;
#(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             ks_ready_s,
    input  logic [KEY_W-1:0] ks_key1,
    input  logic [KEY_W-1:0] ks_key2,
    input  logic             ks_ready,
    input  logic             rk_rd_en,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [KEY_W-1:0] rk_dout,
    output logic             rk_dout_valid,
    output logic             keys_valid,
    output logic             busy,
    output logic             err
);

    rk_state_t         state_reg;
    logic [PAIR_W-1:0] pair_cnt_reg;
    logic              wr_en;
    logic              clr;
    logic              rd_ok;
    logic              last_pair;

    assign last_pair = pair_cnt_reg == PAIR_W'(NPAIRS - 1);
    assign wr_en     = (state_reg == LOAD) && ks_ready_s && !load_start;
    assign clr       = ZEROIZE && load_start;
    assign rd_ok     = (state_reg == FULL) && idx_in_range(rk_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            pair_cnt_reg <= '0;
            keys_valid   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else if (load_start) begin
            state_reg    <= LOAD;
            pair_cnt_reg <= '0;
            keys_valid   <= 1'b0;
            busy         <= 1'b1;
            err          <= 1'b0;
        end else if (state_reg == LOAD) begin
            // A fifth pair completes the schedule even if the end strobe arrives with it.
            if (ks_ready_s && last_pair) begin
                state_reg    <= FULL;
                pair_cnt_reg <= pair_cnt_reg + 1'b1;
                keys_valid   <= 1'b1;
                busy         <= 1'b0;
            end else if (ks_ready) begin
                state_reg    <= EMPTY;
                pair_cnt_reg <= ks_ready_s ? pair_cnt_reg + 1'b1 : pair_cnt_reg;
                busy         <= 1'b0;
                err          <= 1'b1;
            end else if (ks_ready_s) begin
                pair_cnt_reg <= pair_cnt_reg + 1'b1;
            end
        end
    end

    kuz_rkey_ram u_ram (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_pair  (pair_cnt_reg),
        .wr_key1  (ks_key1),
        .wr_key2  (ks_key2),
        .rd_req   (rk_rd_en),
        .rd_ok    (rd_ok),
        .rd_idx   (rk_idx),
        .rd_data  (rk_dout),
        .rd_valid (rk_dout_valid)
    );

endmodule

// File: tb/tb_kuz_rkey_store.sv
// Scoreboard bench for kuz_rkey_store: directed schedule scenarios followed by random traffic.
module tb_kuz_rkey_store;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_start = 1'b0;
    logic         ks_ready_s = 1'b0;
    logic [127:0] ks_key1 = '0;
    logic [127:0] ks_key2 = '0;
    logic         ks_ready = 1'b0;
    logic         rk_rd_en = 1'b0;
    logic [3:0]   rk_idx = '0;
    logic [127:0] rk_dout;
    logic         rk_dout_valid;
    logic         keys_valid;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    kuz_rkey_store #(.ZEROIZE(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .ks_ready_s    (ks_ready_s),
        .ks_key1       (ks_key1),
        .ks_key2       (ks_key2),
        .ks_ready      (ks_ready),
        .rk_rd_en      (rk_rd_en),
        .rk_idx        (rk_idx),
        .rk_dout       (rk_dout),
        .rk_dout_valid (rk_dout_valid),
        .keys_valid    (keys_valid),
        .busy          (busy),
        .err           (err)
    );

    typedef struct packed {
        logic [127:0] dout;
        logic         dv;
        logic         kv;
        logic         bsy;
        logic         er;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;

    // Reference model: 0 = no schedule, 1 = collecting pairs, 2 = schedule complete
    logic [127:0] m_keys [10];
    int           m_mode = 0;
    int           m_pairs = 0;
    logic         m_err = 1'b0;
    logic [127:0] m_dout = '0;
    logic         m_dv = 1'b0;

    logic [127:0] gost [10];

    task automatic step(input logic rst, input logic ls, input logic s, input logic r,
                        input logic rd, input logic [3:0] idx,
                        input logic [127:0] k1, input logic [127:0] k2);
        exp_t e;
        @(negedge clk);
        reset = rst; load_start = ls; ks_ready_s = s; ks_ready = r;
        rk_rd_en = rd; rk_idx = idx; ks_key1 = k1; ks_key2 = k2;

        if (rst) begin
            m_dout = '0; m_dv = 1'b0;
        end else if (rd) begin
            if (m_mode == 2 && idx < 10) begin
                m_dout = m_keys[idx]; m_dv = 1'b1;
            end else begin
                m_dout = '0; m_dv = 1'b0;
            end
        end else begin
            m_dv = 1'b0;
        end

        if (rst) begin
            m_mode = 0; m_pairs = 0; m_err = 1'b0;
            for (int i = 0; i < 10; i++) m_keys[i] = '0;
        end else if (ls) begin
            m_mode = 1; m_pairs = 0; m_err = 1'b0;
            for (int i = 0; i < 10; i++) m_keys[i] = '0;
        end else if (m_mode == 1) begin
            if (s) begin
                m_keys[2*m_pairs]   = k1;
                m_keys[2*m_pairs+1] = k2;
                m_pairs++;
            end
            if (m_pairs == 5) m_mode = 2;
            else if (r) begin
                m_mode = 0; m_err = 1'b1;
            end
        end

        e.dout = m_dout; e.dv = m_dv; e.kv = (m_mode == 2); e.bsy = (m_mode == 1); e.er = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 4'd0, '0, '0);
    endtask

    task automatic rd(input logic [3:0] idx);
        step(0, 0, 0, 0, 1, idx, '0, '0);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every expectation describes the outputs right after the edge that consumed it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rk_dout", rk_dout, e.dout);
                chk("rk_dout_valid", 128'(rk_dout_valid), 128'(e.dv));
                chk("keys_valid", 128'(keys_valid), 128'(e.kv));
                chk("busy", 128'(busy), 128'(e.bsy));
                chk("err", 128'(err), 128'(e.er));
                if (e.dv) $display("read idx=%0d dout=%h", rk_idx, rk_dout);
            end
        end
    end

    initial begin
        int wait_cycles;
        gost[0] = 128'h8899aabbccddeeff0011223344556677;
        gost[1] = 128'hfedcba98765432100123456789abcdef;
        gost[2] = 128'hdb31485315694343228d6aef8cc78c44;
        gost[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
        gost[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
        gost[5] = 128'hbd079435165c6432b532e82834da581b;
        gost[6] = 128'h51e640757e8745de705727265a0098b1;
        gost[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
        gost[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
        gost[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
        for (int i = 0; i < 10; i++) m_keys[i] = '0;

        step(1, 0, 0, 0, 0, 4'd0, '0, '0);
        step(1, 1, 1, 1, 1, 4'd0, gost[0], gost[1]);
        rd(4'd0);

        // GOST vector capture and reads of K1, K2, K3, K10
        step(0, 1, 0, 0, 0, 4'd0, '0, '0);
        for (int p = 0; p < 5; p++) step(0, 0, 1, 0, 0, 4'd0, gost[2*p], gost[2*p+1]);
        idle();
        rd(4'd0); rd(4'd1); rd(4'd2); rd(4'd9);
        idle();
        if (m_keys[9] !== 128'h72e9dd7416bcf45b755dbaa88e4a4043) chk("gost_k10", m_keys[9], gost[9]);

        // Strobes while FULL are ignored; read during load_start sees old contents
        step(0, 0, 1, 0, 1, 4'd3, '1, '1);
        step(0, 1, 0, 0, 1, 4'd0, '0, '0);
        rd(4'd0);

        // Fifth pair coincident with end strobe
        for (int p = 0; p < 5; p++) step(0, 0, 1, p == 4, 0, 4'd0, gost[2*p], gost[2*p+1]);
        rd(4'd12);
        idle();
        for (int i = 0; i < 10; i++) rd(4'(i));
        for (int i = 10; i < 16; i++) rd(4'(i));
        idle();

        // Short schedule -> error, then cleared by the next load
        step(0, 1, 0, 0, 0, 4'd0, '0, '0);
        for (int p = 0; p < 3; p++) step(0, 0, 1, 0, 0, 4'd0, gost[2*p], gost[2*p+1]);
        step(0, 0, 0, 1, 0, 4'd0, '0, '0);
        rd(4'd0); rd(4'd5);
        step(0, 0, 1, 0, 0, 4'd0, gost[0], gost[1]);
        step(0, 1, 0, 0, 0, 4'd0, '0, '0);
        step(0, 0, 1, 1, 0, 4'd0, gost[0], gost[1]);
        idle();

        // Reset mid-load, later strobe ignored
        step(0, 1, 0, 0, 0, 4'd0, '0, '0);
        step(0, 0, 1, 0, 0, 4'd0, gost[0], gost[1]);
        step(0, 0, 1, 0, 0, 4'd0, gost[2], gost[3]);
        step(1, 1, 1, 0, 1, 4'd0, '0, '0);
        step(0, 0, 1, 0, 0, 4'd0, gost[4], gost[5]);
        rd(4'd0);

        // load_start with a strobe drops the strobe; slot 0 reads 0 until refilled
        step(0, 1, 0, 0, 0, 4'd0, '0, '0);
        for (int p = 0; p < 5; p++) step(0, 0, 1, 0, 0, 4'd0, gost[2*p], gost[2*p+1]);
        step(0, 1, 1, 0, 0, 4'd0, '1, '1);
        rd(4'd0);
        for (int p = 0; p < 5; p++)
            step(0, 0, 1, 0, 0, 4'd0, (p == 0) ? 128'h0 : gost[2*p], gost[2*p+1]);
        rd(4'd0); rd(4'd1);
        for (int p = 0; p < 5; p++) step(0, 0, 1, 0, 1, 4'(p), gost[2*p], gost[2*p+1]);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [127:0] k1, k2;
            k1 = {$urandom, $urandom, $urandom, $urandom};
            k2 = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 0, 4'($urandom_range(0, 15)), k1, k2);
        end
        idle();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
